// File: rtl/matseq_pkg.sv
// matseq_pkg: shared types, ALU select codes and helpers for matrix_op_sequencer.
package matseq_pkg;

  typedef enum logic [2:0] {
    OP_TRANSPOSE = 3'd0,
    OP_ADD       = 3'd1,
    OP_SUB       = 3'd2,
    OP_MUL       = 3'd3,
    OP_SCALE     = 3'd4,
    OP_DET       = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_SET_K,
    ST_ISSUE,
    ST_WAIT,
    ST_READ,
    ST_PRESENT
  } state_e;

  // ALUMatrixTop select codes
  localparam logic [5:0] SEL_A_BASE   = 6'd0;
  localparam logic [5:0] SEL_B_BASE   = 6'd9;
  localparam logic [5:0] SEL_RES_BASE = 6'd18;
  localparam logic [5:0] SEL_DET      = 6'd27;
  localparam logic [5:0] SEL_TRANS    = 6'd28;
  localparam logic [5:0] SEL_ADD      = 6'd29;
  localparam logic [5:0] SEL_SUB      = 6'd30;
  localparam logic [5:0] SEL_MUL      = 6'd31;
  localparam logic [5:0] SEL_SCALE    = 6'd32;
  localparam logic [5:0] SEL_DETOP    = 6'd33;
  localparam logic [5:0] SEL_SETK     = 6'd40;
  localparam logic [5:0] SEL_IDLE     = 6'd18;

  // Operation code presented to the ALU while an op is issued/in flight
  function automatic logic [5:0] op_to_sel(input op_e op);
    logic [5:0] sel;
    case (op)
      OP_TRANSPOSE: sel = SEL_TRANS;
      OP_ADD:       sel = SEL_ADD;
      OP_SUB:       sel = SEL_SUB;
      OP_MUL:       sel = SEL_MUL;
      OP_SCALE:     sel = SEL_SCALE;
      OP_DET:       sel = SEL_DETOP;
      default:      sel = SEL_IDLE;
    endcase
    return sel;
  endfunction

  // Codes 6 and 7 are not operations
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= 3'd5);
  endfunction

endpackage

// File: rtl/matrix_op_sequencer_if.sv
// matrix_op_sequencer_if: command, operand and result handshakes of the sequencer.
// Defining MATSEQ_REUSE_EN adds the cmd_reuse command field.
interface matrix_op_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_scalar;
`ifdef MATSEQ_REUSE_EN
  logic              cmd_reuse;
`endif
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

`ifdef MATSEQ_REUSE_EN
  modport master (
    output cmd_valid, cmd_op, cmd_scalar, cmd_reuse, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, out_last
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_scalar, cmd_reuse, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data, out_last
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_scalar, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, out_last
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_scalar, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data, out_last
  );
`endif

endinterface

// File: rtl/matseq_out_reg.sv
// matseq_out_reg: single-entry valid/ready holding register for result beats.
module matseq_out_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  // Hold the beat until accepted; data stays put afterwards, last is cleared
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: rtl/matrix_op_sequencer.sv
// matrix_op_sequencer: loads operands into ALUMatrixTop, issues one op,
// waits its latency and streams the result back out on a valid/ready port.
// Defining MATSEQ_REUSE_EN lets a command reuse the operands already loaded.
module matrix_op_sequencer
  import matseq_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OP_LAT  = 1,
  parameter int MUL_LAT = 2,
  parameter int RD_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  matrix_op_sequencer_if.slave bus,
  output logic                 err,
  output logic                 busy,
  output logic [5:0]           alu_sel,
  output logic [DATA_W-1:0]    alu_ele_in,
  input  logic [DATA_W-1:0]    alu_ele_out
);

  localparam logic [7:0] OP_LAT_C  = 8'(OP_LAT);
  localparam logic [7:0] MUL_LAT_C = 8'(MUL_LAT);
  localparam logic [7:0] RD_LAT_C  = 8'(RD_LAT);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] scalar_q, scalar_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        ridx_q, ridx_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
`ifdef MATSEQ_REUSE_EN
  logic              loaded_q, loaded_d;
`endif

  logic       cmd_fire;
  logic       in_fire;
  logic       out_fire;
  logic       cap_en;
  logic       cap_last;
  logic [5:0] read_sel;

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.in_ready  = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign out_fire      = bus.out_valid && bus.out_ready;
  assign read_sel      = (op_q == OP_DET) ? SEL_DET : (SEL_RES_BASE + {2'b00, ridx_q});
  assign busy          = (state_q != ST_IDLE);
  assign err           = err_q;

  // Next-state logic and ALU drive; alu_sel falls back to a harmless read
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    scalar_d   = scalar_q;
    idx_d      = idx_q;
    ridx_d     = ridx_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
`ifdef MATSEQ_REUSE_EN
    loaded_d   = loaded_q;
`endif
    cap_en     = 1'b0;
    cap_last   = 1'b0;
    alu_sel    = SEL_IDLE;
    alu_ele_in = '0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (op_is_legal(bus.cmd_op)) begin
            op_d     = op_e'(bus.cmd_op);
            scalar_d = bus.cmd_scalar;
            idx_d    = 4'd0;
            ridx_d   = 4'd0;
            state_d  = ST_LOAD_A;
`ifdef MATSEQ_REUSE_EN
            // Skip loading only when the ALU holds operands of a completed command
            if (bus.cmd_reuse && loaded_q) begin
              state_d = (op_e'(bus.cmd_op) == OP_SCALE) ? ST_SET_K : ST_ISSUE;
            end
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_LOAD_A: begin
        if (in_fire) begin
          alu_sel    = SEL_A_BASE + {2'b00, idx_q};
          alu_ele_in = bus.in_data;
          if (idx_q == 4'd8) begin
            idx_d = 4'd0;
            case (op_q)
              OP_ADD, OP_SUB, OP_MUL: state_d = ST_LOAD_B;
              OP_SCALE:               state_d = ST_SET_K;
              default:                state_d = ST_ISSUE;
            endcase
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      ST_LOAD_B: begin
        if (in_fire) begin
          alu_sel    = SEL_B_BASE + {2'b00, idx_q};
          alu_ele_in = bus.in_data;
          if (idx_q == 4'd8) begin
            idx_d   = 4'd0;
            state_d = ST_ISSUE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      ST_SET_K: begin
        alu_sel    = SEL_SETK;
        alu_ele_in = scalar_q;
        state_d    = ST_ISSUE;
      end

      ST_ISSUE: begin
        alu_sel    = op_to_sel(op_q);
        alu_ele_in = (op_q == OP_SCALE) ? scalar_q : '0;
        cnt_d      = (op_q == OP_MUL) ? MUL_LAT_C : OP_LAT_C;
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        alu_sel = op_to_sel(op_q);
        if (cnt_q <= 8'd1) begin
          ridx_d  = 4'd0;
          cnt_d   = RD_LAT_C;
          state_d = ST_READ;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_READ: begin
        alu_sel = read_sel;
        if (cnt_q <= 8'd1) begin
          cap_en   = 1'b1;
          cap_last = (op_q == OP_DET) || (ridx_q == 4'd8);
          state_d  = ST_PRESENT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_PRESENT: begin
        alu_sel = read_sel;
        if (out_fire) begin
          if (bus.out_last) begin
            state_d  = ST_IDLE;
`ifdef MATSEQ_REUSE_EN
            loaded_d = 1'b1;
`endif
          end else begin
            ridx_d  = ridx_q + 4'd1;
            cnt_d   = RD_LAT_C;
            state_d = ST_READ;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_TRANSPOSE;
      scalar_q <= '0;
      idx_q    <= 4'd0;
      ridx_q   <= 4'd0;
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
`ifdef MATSEQ_REUSE_EN
      loaded_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      scalar_q <= scalar_d;
      idx_q    <= idx_d;
      ridx_q   <= ridx_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`ifdef MATSEQ_REUSE_EN
      loaded_q <= loaded_d;
`endif
    end
  end

  matseq_out_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (cap_en),
    .load_data (alu_ele_out),
    .load_last (cap_last),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .out_last  (bus.out_last)
  );

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// tb_matrix_op_sequencer: directed bench with a behavioural ALUMatrixTop model.
module tb_matrix_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        err;
  logic        busy;
  logic [5:0]  alu_sel;
  logic [31:0] alu_ele_in;
  logic [31:0] alu_ele_out;

  int checks   = 0;
  int failures = 0;
  int cyc_ctr  = 0;
  int last_edge = 0;
  int setk_cnt  = 0;

  logic [31:0] beat_q[$];
  logic        lastf_q[$];
  logic [31:0] a_v[9];
  logic [31:0] b_v[9];
  logic [31:0] exp_v[9];

  matrix_op_sequencer_if #(.DATA_W(32)) bus ();

  matrix_op_sequencer #(
    .DATA_W(32), .OP_LAT(1), .MUL_LAT(2), .RD_LAT(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .err         (err),
    .busy        (busy),
    .alu_sel     (alu_sel),
    .alu_ele_in  (alu_ele_in),
    .alu_ele_out (alu_ele_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  // Behavioural ALUMatrixTop: register writes and op evaluation on the clock edge
  logic [31:0] ma[9], mb[9], mr[9], mk, mdet;
  always @(posedge clk) begin : alu_model
    int s;
    s = int'(alu_sel);
    if (s < 9) ma[s] <= alu_ele_in;
    else if (s < 18) mb[s-9] <= alu_ele_in;
    else if (s == 40) mk <= alu_ele_in;
    else if (s >= 28 && s <= 33) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          case (s)
            28: mr[i*3+j] <= ma[j*3+i];
            29: mr[i*3+j] <= ma[i*3+j] + mb[i*3+j];
            30: mr[i*3+j] <= ma[i*3+j] - mb[i*3+j];
            31: mr[i*3+j] <= ma[i*3]*mb[j] + ma[i*3+1]*mb[3+j] + ma[i*3+2]*mb[6+j];
            32: mr[i*3+j] <= ma[i*3+j] * mk;
            default: ;
          endcase
        end
      end
      if (s == 33)
        mdet <= ma[0]*(ma[4]*ma[8] - ma[5]*ma[7])
              - ma[1]*(ma[3]*ma[8] - ma[5]*ma[6])
              + ma[2]*(ma[3]*ma[7] - ma[4]*ma[6]);
    end
  end

  always_comb begin
    alu_ele_out = '0;
    if (int'(alu_sel) >= 18 && int'(alu_sel) <= 26) alu_ele_out = mr[int'(alu_sel) - 18];
    else if (alu_sel == 6'd27) alu_ele_out = mdet;
  end

  // Monitor on the falling edge: accepted beats and SET_K writes of scalar 5
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      beat_q.push_back(bus.out_data);
      lastf_q.push_back(bus.out_last);
      if (bus.out_last) last_edge <= cyc_ctr + 1;
    end
    if (alu_sel == 6'd40 && alu_ele_in == 32'd5) setk_cnt <= setk_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cmd_ready"},  32'(bus.cmd_ready), 32'd1);
    check({tag, "_in_ready"},   32'(bus.in_ready),  32'd0);
    check({tag, "_out_valid"},  32'(bus.out_valid), 32'd0);
    check({tag, "_out_last"},   32'(bus.out_last),  32'd0);
    check({tag, "_out_data"},   bus.out_data,       32'd0);
    check({tag, "_err"},        32'(err),           32'd0);
    check({tag, "_busy"},       32'(busy),          32'd0);
    check({tag, "_alu_sel"},    32'(alu_sel),       32'd18);
    check({tag, "_alu_ele_in"}, alu_ele_in,         32'd0);
  endtask

  // One command: accept, load n_load operands, collect n_out beats, check
  task automatic run_op(input logic [2:0] op, input logic [31:0] scalar, input int n_load,
                        input int n_out, input int stall_beat, input bit poke,
                        input int exp_lat, input string tag);
    int cyc;
    int stalls;
    int base;
    int cmd_edge;
    base = beat_q.size();
    cyc = 0;
    while (!bus.cmd_ready && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_scalar = scalar;
    @(posedge clk); #1;
    cmd_edge = cyc_ctr;
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < n_load; i++) begin
      cyc = 0;
      while (!bus.in_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
      bus.in_valid = 1'b1;
      bus.in_data  = (i < 9) ? a_v[i] : b_v[i-9];
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    cyc = 0; stalls = 0;
    while ((beat_q.size() - base) < n_out && cyc < 200) begin
      if (poke && cyc < 3) begin
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd5;
        check({tag, "_busy_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
      end else bus.cmd_valid = 1'b0;
      if (stall_beat >= 0 && bus.out_valid && (beat_q.size() - base) == stall_beat && stalls < 3) begin
        bus.out_ready = 1'b0; stalls++;
        check({tag, "_hold"}, bus.out_data, exp_v[stall_beat]);
      end else bus.out_ready = 1'b1;
      @(posedge clk); #1; cyc++;
    end
    bus.cmd_valid = 1'b0; bus.out_ready = 1'b1;
    check({tag, "_beats"}, 32'(beat_q.size() - base), 32'(n_out));
    for (int i = 0; i < n_out; i++) begin
      if (base + i < beat_q.size()) begin
        check($sformatf("%s_data%0d", tag, i), beat_q[base+i], exp_v[i]);
        check($sformatf("%s_last%0d", tag, i), 32'(lastf_q[base+i]), 32'(i == n_out - 1));
      end
    end
    check({tag, "_latency"}, 32'(last_edge - cmd_edge), 32'(exp_lat));
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_no_extra"}, 32'(beat_q.size() - base), 32'(n_out));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_err_end"}, 32'(err), 32'd0);
    $display("txn %s op=%0d beats=%0d latency=%0d", tag, op, beat_q.size() - base, last_edge - cmd_edge);
  endtask

  initial begin
    int k0;
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_scalar = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
`ifdef MATSEQ_REUSE_EN
    bus.cmd_reuse = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    a_v = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    b_v = '{0, 1, 2, 3, 4, 5, 6, 7, 8};

    exp_v = '{0, 2, 4, 6, 8, 10, 12, 14, 16};
    run_op(3'd1, 32'd0, 18, 9, -1, 1'b0, 38, "add");

    exp_v = '{15, 18, 21, 42, 54, 66, 69, 90, 111};
    run_op(3'd3, 32'd0, 18, 9, -1, 1'b0, 39, "mul");

    exp_v = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
    run_op(3'd0, 32'd0, 9, 9, -1, 1'b0, 29, "trans");

    k0 = setk_cnt;
    exp_v = '{0, 5, 10, 15, 20, 25, 30, 35, 40};
    run_op(3'd4, 32'd5, 9, 9, -1, 1'b0, 30, "scale");
    check("scale_setk_once", 32'(setk_cnt - k0), 32'd1);

    a_v = '{0, 2, 2, 3, 4, 8, 6, 17, 18};
    exp_v = '{42, 0, 0, 0, 0, 0, 0, 0, 0};
    run_op(3'd5, 32'd0, 9, 1, -1, 1'b0, 13, "det42");

    a_v = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    exp_v = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_op(3'd5, 32'd0, 9, 1, -1, 1'b0, 13, "det0");

    exp_v = '{0, 2, 4, 6, 8, 10, 12, 14, 16};
    run_op(3'd1, 32'd0, 18, 9, 3, 1'b1, 41, "bp");

    // Illegal op: one-cycle err, no state change
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd7;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("ill_err_pulse", 32'(err), 32'd1);
    check("ill_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("ill_err_clear", 32'(err), 32'd0);
    check("ill_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    $display("txn illegal op=7");

    // Reset in the middle of LOAD_A
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_data = a_v[i];
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("midrst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle("midrst");
    reset = 1'b0;
    $display("txn reset_abort beats_loaded=5");
    @(posedge clk); #1;

    exp_v = '{0, 2, 4, 6, 8, 10, 12, 14, 16};
    run_op(3'd1, 32'd0, 18, 9, -1, 1'b0, 38, "add_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
